// File: rtl/ibuffer_mq_if.sv
// ---------------------------------------------------------------------------
// ibuffer_mq_if
//   Bundle of the fetch-side and decode-side signals of the instruction
//   buffer. The buffer itself connects through the 'slave' modport; the
//   environment (fetch + decode, or a testbench) uses 'master'.
//
//   Handshake semantics (both sides, sampled on the rising clock edge):
//     - Fetch group is accepted when fetch_ready && |fetch_valid && !flush.
//       fetch_ready depends on registered occupancy only, never on
//       deq_ready. A refused group must be held by fetch until accepted.
//     - Decode slots are consumed when deq_ready && !flush; every slot whose
//       ibuffer_instr_valid bit is set is taken (all or nothing).
//     - flush wins over both and empties the buffer at the next edge.
//
//   Signals:
//     fetch_valid          per-slot valid mask from fetch (any pattern)
//     fetch_inst/fetch_pc  slot i at [i*W +: W]
//     fetch_ready          buffer can take a full ENQ_WIDTH group
//     flush                discard all contents
//     deq_ready            decode consumes every presented slot
//     ibuffer_instr_valid  per-slot valid to decode, oldest in slot 0
//     ibuffer_inst_out     head instructions
//     ibuffer_pc_out       matching PCs
//     count                current occupancy
// ---------------------------------------------------------------------------
interface ibuffer_mq_if #(
    parameter int DEPTH      = 16,
    parameter int ENQ_WIDTH  = 4,
    parameter int DEQ_WIDTH  = 2,
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 48
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENQ_WIDTH-1:0]            fetch_valid;
    logic [ENQ_WIDTH*INST_WIDTH-1:0] fetch_inst;
    logic [ENQ_WIDTH*PC_WIDTH-1:0]   fetch_pc;
    logic                            fetch_ready;
    logic                            flush;
    logic                            deq_ready;
    logic [DEQ_WIDTH-1:0]            ibuffer_instr_valid;
    logic [DEQ_WIDTH*INST_WIDTH-1:0] ibuffer_inst_out;
    logic [DEQ_WIDTH*PC_WIDTH-1:0]   ibuffer_pc_out;
    logic [CNT_W-1:0]                count;

    modport slave (
        input  fetch_valid,
        input  fetch_inst,
        input  fetch_pc,
        input  flush,
        input  deq_ready,
        output fetch_ready,
        output ibuffer_instr_valid,
        output ibuffer_inst_out,
        output ibuffer_pc_out,
        output count
    );

    modport master (
        output fetch_valid,
        output fetch_inst,
        output fetch_pc,
        output flush,
        output deq_ready,
        input  fetch_ready,
        input  ibuffer_instr_valid,
        input  ibuffer_inst_out,
        input  ibuffer_pc_out,
        input  count
    );
endinterface

// File: rtl/ibuffer_mq.sv
// ---------------------------------------------------------------------------
// ibuffer_mq
//   Multi-entry instruction buffer between fetch and decode. Up to ENQ_WIDTH
//   instructions are written per cycle (sparse masks are compacted so holes
//   never occupy entries) and up to DEQ_WIDTH are presented in program order
//   with show-ahead, combinational-from-register outputs.
//
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset (sync release expected)
//     bus      ibuffer_mq_if.slave, see the interface header for the
//              handshake rules and per-signal meaning
//
//   Storage is a circular array indexed by head/tail pointers of
//   log2(DEPTH) bits; wrap-around is plain pointer overflow. Occupancy is
//   kept in a separate counter so full and empty are unambiguous.
// ---------------------------------------------------------------------------
module ibuffer_mq #(
    parameter int DEPTH      = 16,
    parameter int ENQ_WIDTH  = 4,
    parameter int DEQ_WIDTH  = 2,
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 48
) (
    input  logic          clock,
    input  logic          reset_n,
    ibuffer_mq_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Highest occupancy at which a whole fetch group still fits.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - ENQ_WIDTH);
    localparam logic [CNT_W-1:0] DEQ_MAX   = CNT_W'(DEQ_WIDTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [INST_WIDTH-1:0] mem_inst_q [DEPTH];
    logic [PC_WIDTH-1:0]   mem_pc_q   [DEPTH];

    // -----------------------------------------------------------------------
    // Enqueue side
    // -----------------------------------------------------------------------
    logic                  enq_fire;
    logic                  deq_fire;
    logic [CNT_W-1:0]      enq_cnt;                // popcount(fetch_valid)
    logic [PTR_W-1:0]      slot_off [ENQ_WIDTH];   // compaction offset per slot
    logic [PTR_W-1:0]      wr_idx   [ENQ_WIDTH];
    logic [CNT_W-1:0]      enq_add;
    logic [CNT_W-1:0]      deq_sub;

    assign bus.fetch_ready = (count_q <= READY_MAX);

    assign enq_fire = bus.fetch_ready && (|bus.fetch_valid) && !bus.flush;
    assign deq_fire = bus.deq_ready && !bus.flush;

    // Running prefix count: a valid slot lands at tail + (number of valid
    // slots below it), which squeezes the invalid holes out of the group.
    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            slot_off[i] = enq_cnt[PTR_W-1:0];
            if (bus.fetch_valid[i]) begin
                enq_cnt = enq_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            wr_idx[i] = tail_q + slot_off[i];
        end
    end

    // -----------------------------------------------------------------------
    // Dequeue side: every presented slot leaves together, so the number
    // removed is simply min(count, DEQ_WIDTH).
    // -----------------------------------------------------------------------
    always_comb begin
        enq_add = '0;
        deq_sub = '0;
        if (enq_fire) begin
            enq_add = enq_cnt;
        end
        if (deq_fire) begin
            deq_sub = (count_q >= DEQ_MAX) ? DEQ_MAX : count_q;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state pointers and occupancy. Flush overrides any same-cycle
    // enqueue or dequeue. An enqueue is only allowed at count <= DEPTH -
    // ENQ_WIDTH, so count + k never exceeds DEPTH, and deq_sub never exceeds
    // count, so the counter cannot wrap either way.
    // -----------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + deq_sub[PTR_W-1:0];
            tail_d  = tail_q + enq_add[PTR_W-1:0];
            count_d = count_q + enq_add - deq_sub;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload array carries no reset: entries are only observed while their
    // valid bit (derived from the reset counter) is set.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (bus.fetch_valid[i]) begin
                    mem_inst_q[wr_idx[i]] <= bus.fetch_inst[i*INST_WIDTH +: INST_WIDTH];
                    mem_pc_q[wr_idx[i]]   <= bus.fetch_pc[i*PC_WIDTH +: PC_WIDTH];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Show-ahead presentation: slot j reads entry head + j straight from the
    // registers. Newly written entries become visible the cycle after the
    // write; there is no fetch-to-decode bypass.
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] rd_idx [DEQ_WIDTH];

    for (genvar j = 0; j < DEQ_WIDTH; j++) begin : g_out
        assign rd_idx[j]                                      = head_q + PTR_W'(j);
        assign bus.ibuffer_instr_valid[j]                     = (count_q > CNT_W'(j));
        assign bus.ibuffer_inst_out[j*INST_WIDTH +: INST_WIDTH] = mem_inst_q[rd_idx[j]];
        assign bus.ibuffer_pc_out[j*PC_WIDTH +: PC_WIDTH]       = mem_pc_q[rd_idx[j]];
    end

    assign bus.count = count_q;

endmodule

// File: tb/tb_ibuffer_mq.sv
// ---------------------------------------------------------------------------
// tb_ibuffer_mq
//   Directed plus random-stimulus bench for ibuffer_mq (DEPTH=16, ENQ=4,
//   DEQ=2). The driver pushes accepted fetch entries into exp_q; a monitor
//   on the falling edge checks occupancy, ready, valids and head data
//   against exp_q and retires entries on dequeue / flush. A few hand-computed
//   checkpoints are checked directly by the main sequence.
// ---------------------------------------------------------------------------
module tb_ibuffer_mq;
  localparam int DEPTH = 16;
  localparam int ENQ   = 4;
  localparam int DEQ   = 2;
  localparam int IW    = 32;
  localparam int PW    = 48;
  localparam int EW    = IW + PW;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ibuffer_mq_if #(
    .DEPTH(DEPTH), .ENQ_WIDTH(ENQ), .DEQ_WIDTH(DEQ),
    .INST_WIDTH(IW), .PC_WIDTH(PW)
  ) bus ();

  ibuffer_mq #(
    .DEPTH(DEPTH), .ENQ_WIDTH(ENQ), .DEQ_WIDTH(DEQ),
    .INST_WIDTH(IW), .PC_WIDTH(PW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_cmp    = 0;
  int            n_bad    = 0;
  bit            mon_en   = 1'b0;
  int            seen_cnt = 0;
  int            n_mon;
  logic [EW-1:0] e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (mon_en) begin
      n_mon = exp_q.size();
      chk("count", 64'(bus.count), 64'(n_mon));
      chk("count_le_depth", 64'(bus.count <= 5'(DEPTH)), 64'd1);
      chk("fetch_ready", 64'(bus.fetch_ready), 64'((DEPTH - n_mon) >= ENQ));
      chk("instr_valid", 64'(bus.ibuffer_instr_valid), 64'({n_mon >= 2, n_mon >= 1}));
      for (int j = 0; j < DEQ; j++) begin
        if (j < n_mon) begin
          e = exp_q[j];
          chk("inst_out", 64'(bus.ibuffer_inst_out[j*IW +: IW]), 64'(e[IW-1:0]));
          chk("pc_out", 64'(bus.ibuffer_pc_out[j*PW +: PW]), 64'(e[EW-1:IW]));
        end
      end
      seen_cnt = n_mon;
      if (bus.flush) begin
        exp_q.delete();
      end else if (bus.deq_ready) begin
        for (int j = 0; j < DEQ; j++) begin
          if (j < n_mon) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [ENQ-1:0] v, input logic [ENQ*IW-1:0] ins,
                       input logic [ENQ*PW-1:0] pcs, input logic dq, input logic fl);
    @(posedge clock);
    #1;
    bus.fetch_valid = v;
    bus.fetch_inst  = ins;
    bus.fetch_pc    = pcs;
    bus.deq_ready   = dq;
    bus.flush       = fl;
    @(negedge clock);
    #1;
    // seen_cnt is the occupancy the monitor just observed for this cycle.
    if (!fl && v != '0 && (DEPTH - seen_cnt) >= ENQ) begin
      for (int i = 0; i < ENQ; i++) begin
        if (v[i]) exp_q.push_back({pcs[i*PW +: PW], ins[i*IW +: IW]});
      end
    end
  endtask

  task automatic idle(input logic dq);
    cycle('0, '0, '0, dq, 1'b0);
  endtask

  function automatic logic [ENQ*IW-1:0] g_inst(input logic [IW-1:0] b);
    logic [ENQ*IW-1:0] g;
    for (int i = 0; i < ENQ; i++) g[i*IW +: IW] = b + IW'(i);
    return g;
  endfunction

  function automatic logic [ENQ*PW-1:0] g_pc(input logic [PW-1:0] b);
    logic [ENQ*PW-1:0] g;
    for (int i = 0; i < ENQ; i++) g[i*PW +: PW] = b + PW'(4 * i);
    return g;
  endfunction

  task automatic hand_chk(input string tag, input int cnt, input logic rdy,
                          input logic [1:0] vld, input logic [IW-1:0] i0,
                          input logic [IW-1:0] i1, input logic [PW-1:0] p0);
    chk({tag, "_count"}, 64'(bus.count), 64'(cnt));
    chk({tag, "_ready"}, 64'(bus.fetch_ready), 64'(rdy));
    chk({tag, "_valid"}, 64'(bus.ibuffer_instr_valid), 64'(vld));
    if (vld[0]) begin
      chk({tag, "_inst0"}, 64'(bus.ibuffer_inst_out[0 +: IW]), 64'(i0));
      chk({tag, "_pc0"}, 64'(bus.ibuffer_pc_out[0 +: PW]), 64'(p0));
    end
    if (vld[1]) chk({tag, "_inst1"}, 64'(bus.ibuffer_inst_out[IW +: IW]), 64'(i1));
  endtask

  // ---------------- main sequence ----------------
  logic [ENQ*IW-1:0] sp_i;
  logic [ENQ*PW-1:0] sp_p;
  logic [ENQ*IW-1:0] r_i;
  logic [ENQ*PW-1:0] r_p;
  logic [63:0]       r64;

  initial begin
    bus.fetch_valid = '0;
    bus.fetch_inst  = '0;
    bus.fetch_pc    = '0;
    bus.deq_ready   = 1'b0;
    bus.flush       = 1'b0;

    // Reset values while reset is held
    #3;
    hand_chk("in_reset", 0, 1'b1, 2'b00, '0, '0, '0);
    #9;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    idle(1'b0);
    hand_chk("idle", 0, 1'b1, 2'b00, '0, '0, '0);

    // Full group, no dequeue
    cycle(4'hF, g_inst(32'hA0), g_pc(48'h1000), 1'b0, 1'b0);
    idle(1'b0);
    hand_chk("enq4", 4, 1'b1, 2'b11, 32'hA0, 32'hA1, 48'h1000);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    hand_chk("drain4", 0, 1'b1, 2'b00, '0, '0, '0);

    // Sparse mask 1010: holes in slots 0 and 2 carry junk
    sp_i = {32'hB3, 32'hEE2, 32'hB1, 32'hEE0};
    sp_p = {48'h200C, 48'h2008, 48'h2004, 48'h2000};
    cycle(4'b1010, sp_i, sp_p, 1'b0, 1'b0);
    idle(1'b0);
    hand_chk("sparse", 2, 1'b1, 2'b11, 32'hB1, 32'hB3, 48'h2004);
    idle(1'b1);
    idle(1'b0);
    hand_chk("sparse_deq", 0, 1'b1, 2'b00, '0, '0, '0);

    // Fill to 13 starting at entry 6, so the tail wraps past entry 15
    for (int k = 0; k < 3; k++)
      cycle(4'hF, g_inst(32'hC00 + 32'(4 * k)), g_pc(48'h3000 + 48'(16 * k)), 1'b0, 1'b0);
    cycle(4'b0001, g_inst(32'hC0C), g_pc(48'h3030), 1'b0, 1'b0);
    idle(1'b0);
    hand_chk("fill13", 13, 1'b0, 2'b11, 32'hC00, 32'hC01, 48'h3000);

    // Fetch group held for 3 cycles while decode drains
    cycle(4'hF, g_inst(32'hD0), g_pc(48'h4000), 1'b1, 1'b0);
    hand_chk("hold1", 13, 1'b0, 2'b11, 32'hC00, 32'hC01, 48'h3000);
    cycle(4'hF, g_inst(32'hD0), g_pc(48'h4000), 1'b1, 1'b0);
    hand_chk("hold2", 11, 1'b1, 2'b11, 32'hC02, 32'hC03, 48'h3008);
    cycle(4'hF, g_inst(32'hD0), g_pc(48'h4000), 1'b1, 1'b0);
    hand_chk("hold3", 13, 1'b0, 2'b11, 32'hC04, 32'hC05, 48'h3010);
    idle(1'b0);
    hand_chk("hold_end", 11, 1'b1, 2'b11, 32'hC06, 32'hC07, 48'h3018);

    // Drain across the wrap; last dequeue sees a single valid entry
    repeat (5) idle(1'b1);
    idle(1'b1);
    hand_chk("single", 1, 1'b1, 2'b01, 32'hD3, '0, 48'h400C);
    idle(1'b0);
    hand_chk("empty", 0, 1'b1, 2'b00, '0, '0, '0);

    // Flush beats simultaneous enqueue and dequeue
    cycle(4'hF, g_inst(32'hE0), g_pc(48'h5000), 1'b0, 1'b0);
    cycle(4'b0011, g_inst(32'hE4), g_pc(48'h5010), 1'b0, 1'b0);
    idle(1'b0);
    hand_chk("pre_flush", 6, 1'b1, 2'b11, 32'hE0, 32'hE1, 48'h5000);
    cycle(4'hF, g_inst(32'hF0), g_pc(48'h6000), 1'b1, 1'b1);
    idle(1'b0);
    hand_chk("post_flush", 0, 1'b1, 2'b00, '0, '0, '0);

    // Asynchronous reset mid-run at count 9
    cycle(4'hF, g_inst(32'h100), g_pc(48'h7000), 1'b0, 1'b0);
    cycle(4'hF, g_inst(32'h104), g_pc(48'h7010), 1'b0, 1'b0);
    cycle(4'b0001, g_inst(32'h108), g_pc(48'h7020), 1'b0, 1'b0);
    idle(1'b0);
    hand_chk("pre_reset", 9, 1'b1, 2'b11, 32'h100, 32'h101, 48'h7000);
    @(posedge clock);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    hand_chk("async_reset", 0, 1'b1, 2'b00, '0, '0, '0);
    exp_q.delete();
    seen_cnt = 0;
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    // Random mix against the queue model
    repeat (1500) begin
      for (int i = 0; i < ENQ; i++) begin
        r_i[i*IW +: IW] = $urandom;
        r64 = {$urandom, $urandom};
        r_p[i*PW +: PW] = r64[PW-1:0];
      end
      cycle(ENQ'($urandom_range(0, 15)), r_i, r_p, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0));
    end
    repeat (10) idle(1'b1);
    idle(1'b0);
    hand_chk("final_empty", 0, 1'b1, 2'b00, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
